// File: rtl/afu_dfh_csr_avmm_slave.sv
// AFU DFH/UUID CSR slave: scratch bank, pipelined reads, waitrequest.
// Define AFU_DFH_CSR_PERF_CNT_EN for the perf counters in words 6/7.
module afu_dfh_csr_avmm_slave #(
  parameter logic [63:0] AFU_ID_H          = 64'h331D_B30C_9885_41EA,
  parameter logic [63:0] AFU_ID_L          = 64'h9081_F88B_8F65_5CAA,
  parameter logic [3:0]  DFH_FEATURE_TYPE  = 4'b0001,
  parameter logic [3:0]  DFH_AFU_MINOR_REV = 4'b0,
  parameter logic [3:0]  DFH_AFU_MAJOR_REV = 4'b0,
  parameter logic        DFH_END_OF_LIST   = 1'b1,
  parameter logic [23:0] DFH_NEXT_OFFSET   = 24'b0,
  parameter logic [11:0] DFH_FEATURE_ID    = 12'b0,
  parameter logic [23:0] NEXT_AFU_OFFSET   = 24'b0,
  parameter int          NUM_SCRATCH       = 2,
  parameter int          ADDR_WIDTH        = 4,
  parameter int          READ_LATENCY      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] avmm_address,
  input  logic                  avmm_read,
  input  logic                  avmm_write,
  input  logic [63:0]           avmm_writedata,
  input  logic [7:0]            avmm_byteenable,
  output logic                  avmm_waitrequest,
  output logic [63:0]           avmm_readdata,
  output logic                  avmm_readdatavalid
);

  localparam int XW  = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
  localparam int SIW = (NUM_SCRATCH > 2) ? $clog2(NUM_SCRATCH) : 1;
  localparam int NSA = 1 << SIW;

  localparam logic [63:0] DFH = {
    DFH_FEATURE_TYPE, 8'b0, DFH_AFU_MINOR_REV, 7'b0,
    DFH_END_OF_LIST, DFH_NEXT_OFFSET,
    DFH_AFU_MAJOR_REV, DFH_FEATURE_ID
  };
  localparam logic [63:0] CAP = {
    48'b0, 8'(READ_LATENCY), 8'(NUM_SCRATCH)
  };

  if (ADDR_WIDTH < 7 && (1 << ADDR_WIDTH) < 8 + NUM_SCRATCH)
  begin : g_aw_chk
    $error("ADDR_WIDTH too small for NUM_SCRATCH");
  end
  if (NUM_SCRATCH < 0 || NUM_SCRATCH > 64) begin : g_ns_chk
    $error("NUM_SCRATCH out of range");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_rl_chk
    $error("READ_LATENCY out of range");
  end

  logic          wait_q;
  logic          init_q;
  logic          rd_acc;
  logic          wr_acc;
  logic [XW-1:0] addr;
  logic          is_scr;
  logic [SIW-1:0] scr_idx;
  logic [63:0]   rd_val;
  logic [63:0]   scratch [NSA];

  logic [READ_LATENCY-1:0] vld_q;
  logic [63:0]             dat_q [READ_LATENCY];

  assign addr    = XW'(avmm_address);
  assign rd_acc  = avmm_read & ~wait_q;
  assign wr_acc  = avmm_write & ~wait_q;
  assign is_scr  = (addr >= XW'(8)) &&
                   (addr < XW'(8 + NUM_SCRATCH));
  assign scr_idx = SIW'(addr - XW'(8));

  // Held high through the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q <= 1'b0;
      wait_q <= 1'b1;
    end else begin
      init_q <= 1'b1;
      wait_q <= ~init_q;
    end
  end

  assign avmm_waitrequest = wait_q;

`ifdef AFU_DFH_CSR_PERF_CNT_EN
  logic [63:0] cyc_cnt;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      if (wr_acc && addr == XW'(6)) cyc_cnt <= '0;
      else cyc_cnt <= cyc_cnt + 64'd1;
      // A clearing write beats any same-cycle increment.
      if (wr_acc && addr == XW'(7)) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        rd_cnt <= rd_cnt + {31'b0, rd_acc};
        wr_cnt <= wr_cnt + {31'b0, wr_acc};
      end
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (addr)
      XW'(0): rd_val = DFH;
      XW'(1): rd_val = AFU_ID_L;
      XW'(2): rd_val = AFU_ID_H;
      XW'(3): rd_val = {40'b0, NEXT_AFU_OFFSET};
      XW'(5): rd_val = CAP;
`ifdef AFU_DFH_CSR_PERF_CNT_EN
      XW'(6): rd_val = cyc_cnt;
      XW'(7): rd_val = {rd_cnt, wr_cnt};
`endif
      default: rd_val = is_scr ? scratch[scr_idx] : '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSA; i++) scratch[i] <= '0;
    end else if (wr_acc && is_scr) begin
      for (int b = 0; b < 8; b++) begin
        if (avmm_byteenable[b])
          scratch[scr_idx][8*b +: 8] <= avmm_writedata[8*b +: 8];
      end
    end
  end

  // Data is zeroed alongside an idle slot so readdata is 0 when not valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      dat_q[0] <= rd_acc ? rd_val : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign avmm_readdatavalid = vld_q[READ_LATENCY-1];
  assign avmm_readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_afu_dfh_csr_avmm_slave.sv
// Scoreboard bench for afu_dfh_csr_avmm_slave (RL=1 and RL=3 instances).
// Counter checks compile in when AFU_DFH_CSR_PERF_CNT_EN is defined.
module tb_afu_dfh_csr_avmm_slave;

  localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;
  localparam logic [63:0] IDL  = 64'h9081_F88B_8F65_5CAA;
  localparam logic [63:0] IDH  = 64'h331D_B30C_9885_41EA;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] cyc;
    logic [1:0]  kind;
  } ent_t;

  logic        clk;
  logic        reset_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [7:0]  addr  [2];
  logic [63:0] wdata [2];
  logic [7:0]  be    [2];
  logic        wreq  [2];
  logic [63:0] rdata [2];
  logic        rvld  [2];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cyc   = '0;
  logic [63:0] cap   = '0;
  ent_t        q0 [$];
  ent_t        q1 [$];

  afu_dfh_csr_avmm_slave #(
    .NUM_SCRATCH(2), .ADDR_WIDTH(8), .READ_LATENCY(1)
  ) u0 (
    .clk(clk), .reset_n(reset_n),
    .avmm_address(addr[0]), .avmm_read(rd[0]),
    .avmm_write(wr[0]), .avmm_writedata(wdata[0]),
    .avmm_byteenable(be[0]), .avmm_waitrequest(wreq[0]),
    .avmm_readdata(rdata[0]), .avmm_readdatavalid(rvld[0])
  );

  afu_dfh_csr_avmm_slave #(
    .NUM_SCRATCH(2), .ADDR_WIDTH(4), .READ_LATENCY(3)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .avmm_address(addr[1][3:0]), .avmm_read(rd[1]),
    .avmm_write(wr[1]), .avmm_writedata(wdata[1]),
    .avmm_byteenable(be[1]), .avmm_waitrequest(wreq[1]),
    .avmm_readdata(rdata[1]), .avmm_readdatavalid(rvld[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  // kind 0: exact, 1: capture, 2: difference from captured value
  task automatic take(input string n, input ent_t e,
                      input logic [63:0] d);
    chk({n, " lat"}, {32'b0, cyc}, {32'b0, e.cyc});
    case (e.kind)
      2'd1: cap = d;
      2'd2: chk({n, " delta"}, d - cap, e.data);
      default: chk({n, " data"}, d, e.data);
    endcase
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rvld[0]) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL mon0 extra got=%h want=none", rdata[0]);
      end else begin
        e = q0.pop_front();
        take("mon0", e, rdata[0]);
      end
    end
    if (rvld[1]) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL mon1 extra got=%h want=none", rdata[1]);
      end else begin
        e = q1.pop_front();
        take("mon1", e, rdata[1]);
      end
    end
  end

  task automatic op(input int s, input bit r, input bit w,
                    input logic [7:0] a, input logic [63:0] d,
                    input logic [7:0] b, input logic [63:0] e,
                    input logic [1:0] k);
    ent_t t;
    chk("wreq idle", {63'b0, wreq[s]}, 64'd0);
    rd[s] = r; wr[s] = w; addr[s] = a;
    wdata[s] = d; be[s] = b;
    t.data = e;
    t.cyc  = cyc + ((s == 0) ? 32'd1 : 32'd3);
    t.kind = k;
    if (r) begin
      if (s == 0) q0.push_back(t);
      else q1.push_back(t);
    end
    @(posedge clk);
    @(negedge clk);
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  task automatic rdw(input int s, input logic [7:0] a,
                     input logic [63:0] e);
    op(s, 1'b1, 1'b0, a, 64'd0, 8'h00, e, 2'd0);
  endtask

  task automatic wrw(input int s, input logic [7:0] a,
                     input logic [63:0] d, input logic [7:0] b);
    op(s, 1'b0, 1'b1, a, d, b, 64'd0, 2'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst wreq0", {63'b0, wreq[0]}, 64'd1);
    chk("rst wreq1", {63'b0, wreq[1]}, 64'd1);
    chk("rst vld1", {63'b0, rvld[1]}, 64'd0);
    chk("rst data1", rdata[1], 64'd0);
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("wreq edge1 u0", {63'b0, wreq[0]}, 64'd1);
    chk("wreq edge1 u1", {63'b0, wreq[1]}, 64'd1);
    @(negedge clk);
    chk("wreq edge2 u0", {63'b0, wreq[0]}, 64'd0);
    chk("wreq edge2 u1", {63'b0, wreq[1]}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0;
      wdata[i] = '0; be[i] = '0;
    end
    #1;
    do_reset();

    rdw(0, 8'd0, DFH);
    rdw(0, 8'd1, IDL);
    rdw(0, 8'd2, IDH);
    rdw(0, 8'd3, 64'd0);
    rdw(0, 8'd4, 64'd0);
    rdw(0, 8'd5, 64'h0102);

    wrw(0, 8'd8, ONES, 8'hFF);
    wrw(0, 8'd8, 64'd0, 8'h0F);
    rdw(0, 8'd8, 64'hFFFF_FFFF_0000_0000);
    rdw(0, 8'd9, 64'd0);
    wrw(0, 8'd0, ONES, 8'hFF);
    rdw(0, 8'd0, DFH);
    wrw(0, 8'd200, ONES, 8'hFF);
    rdw(0, 8'd200, 64'd0);
    wrw(0, 8'd10, ONES, 8'hFF);
    rdw(0, 8'd10, 64'd0);
    wrw(0, 8'd9, ONES, 8'h00);
    rdw(0, 8'd9, 64'd0);
    op(0, 1'b1, 1'b1, 8'd9, 64'h1234_5678_9ABC_DEF0, 8'hFF,
       64'd0, 2'd0);
    rdw(0, 8'd9, 64'h1234_5678_9ABC_DEF0);
    wrw(0, 8'd9, 64'd0, 8'hA5);
    rdw(0, 8'd9, 64'h0034_0078_9A00_DE00);

    for (int a = 0; a < 6; a++) begin
      case (a)
        0: rdw(1, 8'(a), DFH);
        1: rdw(1, 8'(a), IDL);
        2: rdw(1, 8'(a), IDH);
        5: rdw(1, 8'(a), 64'h0302);
        default: rdw(1, 8'(a), 64'd0);
      endcase
    end
    wrw(1, 8'd8, 64'hCAFE, 8'hFF);
    rdw(1, 8'd8, 64'hCAFE);
    wrw(1, 8'd8, 64'hBEEF, 8'hFF);
    rdw(1, 8'd8, 64'hBEEF);
    repeat (5) @(negedge clk);

    rdw(1, 8'd0, DFH);
    rdw(1, 8'd1, IDL);
    do_reset();
    rdw(1, 8'd8, 64'd0);
    rdw(0, 8'd9, 64'd0);
    rdw(0, 8'd8, 64'd0);

`ifdef AFU_DFH_CSR_PERF_CNT_EN
    wrw(0, 8'd7, 64'd0, 8'h00);
    for (int i = 0; i < 5; i++) rdw(0, 8'd8, 64'd0);
    for (int i = 0; i < 3; i++) wrw(0, 8'd9, 64'(i), 8'hFF);
    rdw(0, 8'd7, 64'h0000_0005_0000_0003);
    wrw(0, 8'd7, ONES, 8'hFF);
    rdw(0, 8'd7, 64'd0);
    op(0, 1'b1, 1'b0, 8'd6, 64'd0, 8'h00, 64'd0, 2'd1);
    repeat (9) @(negedge clk);
    op(0, 1'b1, 1'b0, 8'd6, 64'd0, 8'h00, 64'd10, 2'd2);
    wrw(0, 8'd6, 64'd0, 8'h00);
    rdw(0, 8'd6, 64'd0);
`else
    rdw(0, 8'd6, 64'd0);
    rdw(0, 8'd7, 64'd0);
    wrw(0, 8'd6, ONES, 8'hFF);
    rdw(0, 8'd6, 64'd0);
`endif

    repeat (6) @(negedge clk);
    chk("drain q0", 64'(q0.size()), 64'd0);
    chk("drain q1", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afu_dfh_csr_avmm_slave.md
# afu_dfh_csr_avmm_slave

Parametrised AFU identification and CSR slave on the Avalon-MM CSR interconnect; next generation of the fixed-map AFU ID slave. It presents the DFH header, 128-bit AFU UUID and next-AFU offset. It adds a configurable bank of byte-enabled scratch registers, pipelined reads with `avmm_readdatavalid` and programmable latency, a `avmm_waitrequest` handshake, and optional performance counters.

## Interface
- `AFU_ID_H`, 64'h331D_B30C_9885_41EA: UUID upper 64 bits.
- `AFU_ID_L`, 64'h9081_F88B_8F65_5CAA: UUID lower 64 bits.
- `DFH_FEATURE_TYPE` 4'b0001, `DFH_AFU_MINOR_REV` 4'b0, `DFH_AFU_MAJOR_REV` 4'b0, `DFH_END_OF_LIST` 1'b1, `DFH_NEXT_OFFSET` 24'b0, `DFH_FEATURE_ID` 12'b0: DFH fields.
- `NEXT_AFU_OFFSET`, 24'b0: value returned in word 3.
- `NUM_SCRATCH`, 2: scratch registers, 0..64.
- `ADDR_WIDTH`, 4: word-address width. Must satisfy 2^ADDR_WIDTH >= 8+NUM_SCRATCH; an elaboration-time `$error` fires otherwise.
- `READ_LATENCY`, 1: cycles from accepted read to `avmm_readdatavalid`, 1..3.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `avmm_address` in ADDR_WIDTH: 64-bit word address.
- `avmm_read` in 1: read request.
- `avmm_write` in 1: write request.
- `avmm_writedata` in 64: write data.
- `avmm_byteenable` in 8: byte lanes for writes; ignored on reads.
- `avmm_waitrequest` out 1: stall; request not accepted while high.
- `avmm_readdata` out 64: read data; valid only with `avmm_readdatavalid`, zero otherwise.
- `avmm_readdatavalid` out 1: one-cycle pulse per accepted read.

## Operation
- Register map (RO = writes ignored):
  - 0: DFH {type, 8'b0, minor, 7'b0, eol, next_offset, major, feature_id}, RO.
  - 1: AFU_ID_L, RO.
  - 2: AFU_ID_H, RO.
  - 3: {40'b0, NEXT_AFU_OFFSET}, RO.
  - 4: reserved, reads 0.
  - 5: capability {48'b0, READ_LATENCY[7:0], NUM_SCRATCH[7:0]}, RO.
  - 6: cycle counter (macro).
  - 7: {rd_cnt[31:0], wr_cnt[31:0]} (macro).
  - 8..8+NUM_SCRATCH-1: scratch, RW.
  - All other addresses read 0 and ignore writes.
- Accept rule: a request is accepted on a rising edge with `avmm_read` or `avmm_write` high and `avmm_waitrequest` low.
- Scratch write: byte i is updated only when `avmm_byteenable[i]` = 1. All-zero byteenable is a legal no-op.
- Read and write asserted together at the same address: both are accepted. The read returns the pre-write value; the write then takes effect.
- Reads are fully pipelined, one accepted per cycle. Every accepted read yields exactly one `avmm_readdatavalid` pulse, in order.
- Reset: `avmm_waitrequest` goes high immediately (asynchronous). After `reset_n` rises, it stays high for exactly one more `clk` edge, then drops.
- Reset mid-operation: in-flight reads are discarded and no `avmm_readdatavalid` is issued for them.

## Timing
- Reset values: `avmm_readdata` 0, `avmm_readdatavalid` 0, `avmm_waitrequest` 1, scratch 0, all counters 0.
- Read accepted at edge N: `avmm_readdatavalid` is high and `avmm_readdata` is valid after edge N+READ_LATENCY-1, sampled at edge N+READ_LATENCY.
- Read data is captured at acceptance. A later write does not alter data already in flight.
- Write accepted at edge N: the register holds the new value after edge N. A read accepted at edge N+1 returns it.
- `avmm_waitrequest` never depends combinationally on the request inputs.

## Configuration
- Macro: `AFU_DFH_CSR_PERF_CNT_EN`.
- With the macro defined:
  - Word 6 is a 64-bit free-running `clk` counter. It wraps 2^64-1 -> 0. Any write to word 6, regardless of byteenable, clears it to 0 on the next edge.
  - Word 7: `rd_cnt` and `wr_cnt` count accepted reads and writes, each wrapping at 2^32.
  - Any write to word 7 clears both counters. The clear wins over a simultaneous increment, and the clearing write itself is not counted.
  - A read of word 6 or 7 returns the value at the acceptance edge, before that read is counted.
- Without the macro: words 6 and 7 read 0, ignore writes, and the counter logic is not present.

## Test plan
- Reset, then read words 0,1,2,3 at READ_LATENCY=1 with defaults -> 64'h1000_0100_0000_0000, 64'h9081_F88B_8F65_5CAA, 64'h331D_B30C_9885_41EA, 0. Each arrives 1 cycle after acceptance, and `avmm_waitrequest` is low from the 2nd edge after `reset_n` rises.
- Write 64'hFFFF_FFFF_FFFF_FFFF to word 8 with byteenable 8'hFF, then 64'h0 with byteenable 8'h0F -> word 8 reads 64'hFFFF_FFFF_0000_0000. Word 9 reads 0. Writes to word 0 and word 200 leave them unchanged.
- READ_LATENCY=3, back-to-back reads of words 0..5 on consecutive cycles -> six consecutive `avmm_readdatavalid` pulses, starting 3 cycles after the first acceptance, data in address order. Word 5 = 64'h0000_0000_0000_0302.
- Assert `reset_n` low while 2 reads are in flight -> no `avmm_readdatavalid` for them, scratch returns to 0, `avmm_waitrequest` high at once.
- Macro on: 5 reads and 3 writes to scratch, then read word 7 -> 64'h0000_0005_0000_0003. Write word 7, then read it -> 64'h0000_0000_0000_0000.
- Macro on: read word 6 twice, 10 cycles apart -> difference 10. Write word 6, then read it 1 cycle later -> 0.
